// File: rtl/sv12_dly_mode_sel.sv
// ----------------------------------------------------------------------------
// sv12_dly_mode_sel
//
// Selects an A=>Y rise/fall delay pair from a fixed 5-entry conditional
// table, based on the low three bits of a mode word. Each table entry has a
// mask. An entry is enabled when (mode & mask) != 0. The result is the
// independent unsigned minimum of the rise and fall delays over all enabled
// entries. If no entry is enabled, the result is the default pair
// (DEF_RISE, DEF_FALL).
//
// One entry is scanned per clock, so a lookup takes exactly five cycles from
// accept to dly_valid. The result is held until the consumer takes it.
//
// Ports
//   clk         clock, rising-edge active
//   rst         asynchronous active-high reset
//   cfg_valid   mode word offered
//   cfg_mode    32-bit mode word
//   cfg_ready   block is idle and can accept a mode word
//   dly_valid   selected delay pair available
//   dly_ready   consumer accepts the delay pair
//   dly_rise    selected rise delay (DLY_W bits)
//   dly_fall    selected fall delay (DLY_W bits)
//   any_match   at least one conditional entry was enabled
//   mode_q      last accepted mode word
//   lookup_cnt  number of completed lookups, wraps at 256
// ----------------------------------------------------------------------------
module sv12_dly_mode_sel #(
    parameter int unsigned DLY_W    = 8,
    parameter int unsigned DEF_RISE = 6,
    parameter int unsigned DEF_FALL = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [31:0]      cfg_mode,
    output logic             cfg_ready,
    output logic             dly_valid,
    input  logic             dly_ready,
    output logic [DLY_W-1:0] dly_rise,
    output logic [DLY_W-1:0] dly_fall,
    output logic             any_match,
    output logic [31:0]      mode_q,
    output logic [7:0]       lookup_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    localparam logic [DLY_W-1:0] DEF_R = DLY_W'(DEF_RISE);
    localparam logic [DLY_W-1:0] DEF_F = DLY_W'(DEF_FALL);

    state_t             r_state;
    logic [2:0]         r_idx;
    logic [DLY_W-1:0]   r_acc_rise;
    logic [DLY_W-1:0]   r_acc_fall;
    logic               r_any;
    logic [31:0]        r_mode;
    logic               r_cfg_ready;
    logic               r_dly_valid;
    logic [DLY_W-1:0]   r_dly_rise;
    logic [DLY_W-1:0]   r_dly_fall;
    logic               r_any_match;
    logic [7:0]         r_lookup_cnt;

    logic [2:0]         w_mask;
    logic [DLY_W-1:0]   w_rise;
    logic [DLY_W-1:0]   w_fall;
    logic               w_en;
    logic [DLY_W-1:0]   w_rise_nxt;
    logic [DLY_W-1:0]   w_fall_nxt;
    logic               w_any_nxt;

    // Conditional delay table, indexed by the scan position.
    always_comb begin
        w_mask = '0;
        w_rise = '0;
        w_fall = '0;
        case (r_idx)
            3'd0: begin w_mask = 3'd5; w_rise = DLY_W'(5); w_fall = DLY_W'(9); end
            3'd1: begin w_mask = 3'd4; w_rise = DLY_W'(4); w_fall = DLY_W'(8); end
            3'd2: begin w_mask = 3'd3; w_rise = DLY_W'(6); w_fall = DLY_W'(5); end
            3'd3: begin w_mask = 3'd2; w_rise = DLY_W'(3); w_fall = DLY_W'(2); end
            3'd4: begin w_mask = 3'd1; w_rise = DLY_W'(7); w_fall = DLY_W'(7); end
            default: begin end
        endcase
    end

    // Running minima. Use strict less-than so that a tie keeps the current
    // accumulator value.
    always_comb begin
        w_en       = |(r_mode[2:0] & w_mask);
        w_rise_nxt = (w_en && (w_rise < r_acc_rise)) ? w_rise : r_acc_rise;
        w_fall_nxt = (w_en && (w_fall < r_acc_fall)) ? w_fall : r_acc_fall;
        w_any_nxt  = r_any | w_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_acc_rise   <= '1;
            r_acc_fall   <= '1;
            r_any        <= 1'b0;
            r_mode       <= '0;
            r_cfg_ready  <= 1'b1;
            r_dly_valid  <= 1'b0;
            r_dly_rise   <= '0;
            r_dly_fall   <= '0;
            r_any_match  <= 1'b0;
            r_lookup_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        r_mode      <= cfg_mode;
                        r_idx       <= '0;
                        r_acc_rise  <= '1;
                        r_acc_fall  <= '1;
                        r_any       <= 1'b0;
                        r_cfg_ready <= 1'b0;
                        r_state     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    r_acc_rise <= w_rise_nxt;
                    r_acc_fall <= w_fall_nxt;
                    r_any      <= w_any_nxt;
                    if (r_idx == 3'd4) begin
                        // The last entry's contribution is folded in on this
                        // same edge, through the *_nxt values.
                        r_dly_rise  <= w_any_nxt ? w_rise_nxt : DEF_R;
                        r_dly_fall  <= w_any_nxt ? w_fall_nxt : DEF_F;
                        r_any_match <= w_any_nxt;
                        r_dly_valid <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                ST_DONE: begin
                    if (dly_ready) begin
                        r_dly_valid  <= 1'b0;
                        r_lookup_cnt <= r_lookup_cnt + 8'd1;
                        r_cfg_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cfg_ready <= 1'b1;
                    r_dly_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready  = r_cfg_ready;
    assign dly_valid  = r_dly_valid;
    assign dly_rise   = r_dly_rise;
    assign dly_fall   = r_dly_fall;
    assign any_match  = r_any_match;
    assign mode_q     = r_mode;
    assign lookup_cnt = r_lookup_cnt;

endmodule

// File: tb/tb_sv12_dly_mode_sel.sv
// ----------------------------------------------------------------------------
// tb_sv12_dly_mode_sel
//
// Directed testbench for sv12_dly_mode_sel. Inputs are driven on the falling
// clock edge, and outputs are sampled on the falling edge as well.
// ----------------------------------------------------------------------------
module tb_sv12_dly_mode_sel;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic [31:0] cfg_mode;
    logic        cfg_ready;
    logic        dly_valid;
    logic        dly_ready;
    logic [7:0]  dly_rise;
    logic [7:0]  dly_fall;
    logic        any_match;
    logic [31:0] mode_q;
    logic [7:0]  lookup_cnt;

    int unsigned total;
    int unsigned bad;

    sv12_dly_mode_sel #(
        .DLY_W    (8),
        .DEF_RISE (6),
        .DEF_FALL (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_mode   (cfg_mode),
        .cfg_ready  (cfg_ready),
        .dly_valid  (dly_valid),
        .dly_ready  (dly_ready),
        .dly_rise   (dly_rise),
        .dly_fall   (dly_fall),
        .any_match  (any_match),
        .mode_q     (mode_q),
        .lookup_cnt (lookup_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start this task at a falling edge while the DUT is IDLE.
    task automatic lookup(input string tag, input logic [31:0] mode,
                          input logic [7:0] er, input logic [7:0] ef,
                          input logic ea, input logic hold_ready);
        int unsigned n;
        dly_ready = hold_ready;
        cfg_mode  = mode;
        cfg_valid = 1'b1;
        @(negedge clk);                 // accept edge T has passed
        cfg_valid = 1'b0;
        chk({tag, "_cfg_ready_busy"}, {31'd0, cfg_ready}, 32'd0);
        n = 0;
        while (!dly_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 32'd5);
        chk({tag, "_valid"}, {31'd0, dly_valid}, 32'd1);
        chk({tag, "_rise"}, {24'd0, dly_rise}, {24'd0, er});
        chk({tag, "_fall"}, {24'd0, dly_fall}, {24'd0, ef});
        chk({tag, "_any"}, {31'd0, any_match}, {31'd0, ea});
        chk({tag, "_mode_q"}, mode_q, mode);
        dly_ready = 1'b1;
        @(negedge clk);
        dly_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, dly_valid}, 32'd0);
        chk({tag, "_cfg_ready_idle"}, {31'd0, cfg_ready}, 32'd1);
    endtask

    // Lookup with the consumer always ready. Only a timeout is reported.
    task automatic fast_lookup(input logic [31:0] mode);
        int unsigned n;
        dly_ready = 1'b1;
        cfg_mode  = mode;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        n = 0;
        while (!dly_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fast_valid", {31'd0, dly_valid}, 32'd1);
        @(negedge clk);
        dly_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int unsigned seen;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_mode  = '0;
        dly_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_dly_valid", {31'd0, dly_valid}, 32'd0);
        chk("rst_rise", {24'd0, dly_rise}, 32'd0);
        chk("rst_fall", {24'd0, dly_fall}, 32'd0);
        chk("rst_any", {31'd0, any_match}, 32'd0);
        chk("rst_mode_q", mode_q, 32'd0);
        chk("rst_cnt", {24'd0, lookup_cnt}, 32'd0);
        rst = 1'b0;

        // Mode 3 enables entries 0, 2, 3 and 4. The minimum pair is (3,2).
        // dly_ready is held high throughout.
        lookup("m3", 32'd3, 8'd3, 8'd2, 1'b1, 1'b1);
        chk("m3_cnt", {24'd0, lookup_cnt}, 32'd1);

        // No entry is enabled, so the default pair is selected.
        lookup("m0", 32'd0, 8'd6, 8'd9, 1'b0, 1'b0);
        lookup("m8", 32'd8, 8'd6, 8'd9, 1'b0, 1'b0);
        lookup("m1", 32'd1, 8'd5, 8'd5, 1'b1, 1'b0);
        lookup("m4", 32'd4, 8'd4, 8'd8, 1'b1, 1'b0);
        lookup("m5", 32'd5, 8'd4, 8'd5, 1'b1, 1'b0);
        lookup("m6", 32'd6, 8'd3, 8'd2, 1'b1, 1'b1);
        lookup("mneg1", 32'hFFFF_FFFF, 8'd3, 8'd2, 1'b1, 1'b0);
        chk("cnt_after8", {24'd0, lookup_cnt}, 32'd8);

        // Consumer stall. A new mode word offered during DONE is ignored.
        cfg_mode  = 32'd3;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("stall_valid0", {31'd0, dly_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                cfg_mode  = 32'd4;
                cfg_valid = 1'b1;
            end
            @(negedge clk);
            chk("stall_valid", {31'd0, dly_valid}, 32'd1);
            chk("stall_rise", {24'd0, dly_rise}, 32'd3);
            chk("stall_fall", {24'd0, dly_fall}, 32'd2);
            chk("stall_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        end
        cfg_valid = 1'b0;
        chk("stall_mode_q", mode_q, 32'd3);
        dly_ready = 1'b1;
        @(negedge clk);
        dly_ready = 1'b0;
        chk("stall_release_valid", {31'd0, dly_valid}, 32'd0);
        chk("stall_release_ready", {31'd0, cfg_ready}, 32'd1);
        chk("stall_release_mode_q", mode_q, 32'd3);
        chk("stall_cnt", {24'd0, lookup_cnt}, 32'd9);

        // Reset asserted in the middle of SCAN, after two scan edges.
        cfg_mode  = 32'd3;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("arst_valid", {31'd0, dly_valid}, 32'd0);
        chk("arst_rise", {24'd0, dly_rise}, 32'd0);
        chk("arst_fall", {24'd0, dly_fall}, 32'd0);
        chk("arst_any", {31'd0, any_match}, 32'd0);
        chk("arst_mode_q", mode_q, 32'd0);
        chk("arst_cnt", {24'd0, lookup_cnt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dly_valid) seen++;
        end
        chk("arst_no_pulse", seen, 32'd0);
        chk("arst_cnt_hold", {24'd0, lookup_cnt}, 32'd0);
        lookup("m2", 32'd2, 8'd3, 8'd2, 1'b1, 1'b0);
        chk("m2_cnt", {24'd0, lookup_cnt}, 32'd1);

        // Counter wrap.
        do_reset();
        for (int i = 0; i < 255; i++) fast_lookup(i);
        chk("cnt_255", {24'd0, lookup_cnt}, 32'd255);
        fast_lookup(32'd7);
        chk("cnt_wrap", {24'd0, lookup_cnt}, 32'd0);
        chk("wrap_rise", {24'd0, dly_rise}, 32'd3);
        chk("wrap_fall", {24'd0, dly_fall}, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/sv12_dly_mode_sel.md
SV12_DLY_MODE_SEL -- requirements
Module: sv12_dly_mode_sel

Interface
REQ-001 Parameter DLY_W, default 8, width of delay outputs and accumulators.
REQ-002 Parameter DEF_RISE, default 6, unconditional A=>Y rise delay used when no conditional entry is enabled.
REQ-003 Parameter DEF_FALL, default 9, unconditional A=>Y fall delay used when no conditional entry is enabled.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 cfg_valid  input  1  new mode word offered.
REQ-007 cfg_mode  input  32  mode word, two's-complement int.
REQ-008 cfg_ready  output  1  block can accept a mode word.
REQ-009 dly_valid  output  1  selected delay pair is available.
REQ-010 dly_ready  input  1  consumer accepts the delay pair.
REQ-011 dly_rise  output  DLY_W  selected A=>Y rise delay.
REQ-012 dly_fall  output  DLY_W  selected A=>Y fall delay.
REQ-013 any_match  output  1  at least one conditional entry was enabled.
REQ-014 mode_q  output  32  last accepted mode word.
REQ-015 lookup_cnt  output  8  count of completed lookups.

Function
REQ-016 The block SHALL hold a fixed 5-entry table, index:mask:(rise,fall) = 0:5:(5,9), 1:4:(4,8), 2:3:(6,5), 3:2:(3,2), 4:1:(7,7).
REQ-017 Entry i SHALL be enabled when (mode_q & mask_i) != 0; only bits [2:0] of the mode matter.
REQ-018 The FSM SHALL have states IDLE, SCAN, DONE.
REQ-019 IDLE: cfg_ready=1; on edge with cfg_valid=1 -> capture cfg_mode into mode_q, idx=0, acc_rise=acc_fall=all-ones, any=0, go SCAN.
REQ-020 SCAN: cfg_ready=0; each edge evaluates entry idx; if enabled, acc_rise=min(acc_rise,rise_i), acc_fall=min(acc_fall,fall_i) independently, any=1; idx increments.
REQ-021 On the edge evaluating idx=4, the block SHALL register dly_rise/dly_fall = any ? acc : DEF values (including entry 4's contribution), any_match=any, go DONE.
REQ-022 Latency SHALL be exactly 5 cycles: accept at edge T, dly_valid high after edge T+5.
REQ-023 DONE: dly_valid=1 and outputs held stable until an edge with dly_ready=1; on that edge dly_valid drops, lookup_cnt increments (wraps 255->0), go IDLE.
REQ-024 cfg_ready SHALL be 0 in SCAN and DONE; cfg_valid there is ignored and mode_q unchanged.
REQ-025 dly_ready while dly_valid=0 SHALL have no effect.
REQ-026 Rise and fall minima SHALL be unsigned DLY_W comparisons; ties keep current value.
REQ-027 A new lookup SHALL not start in the same edge DONE completes; earliest accept is the next edge from IDLE.

Reset
REQ-028 On rst=1, immediately and independent of clk: state=IDLE, cfg_ready=1, dly_valid=0, dly_rise=0, dly_fall=0, any_match=0, mode_q=0, lookup_cnt=0, idx=0.
REQ-029 Reset during SCAN or DONE SHALL abandon the lookup with no dly_valid pulse and no lookup_cnt increment.
REQ-030 First accept after rst deassertion SHALL be the first rising edge with rst=0 and cfg_valid=1.

Verification
REQ-031 cfg_mode=3, dly_ready=1 -> dly_valid 5 cycles after accept, dly_rise=3, dly_fall=2, any_match=1, lookup_cnt=1.
REQ-032 cfg_mode=0, then cfg_mode=8 -> both give dly_rise=6, dly_fall=9, any_match=0.
REQ-033 cfg_mode=1 -> dly_rise=5, dly_fall=5; cfg_mode=4 -> dly_rise=4, dly_fall=8.
REQ-034 cfg_mode=3 with dly_ready=0 for 10 cycles -> dly_valid and outputs stable, cfg_ready=0, cfg_valid with mode 4 ignored; dly_ready=1 -> IDLE, mode_q still 3.
REQ-035 rst pulse mid-SCAN (after 2 edges) -> all outputs to reset values asynchronously, no dly_valid, lookup_cnt=0; next lookup cfg_mode=2 -> (3,2).
REQ-036 256 back-to-back lookups -> lookup_cnt wraps to 0.
